// File: rtl/cla_adder_if.sv
// Operand/result bundle for cla_adder: operands and valid in one direction, registered
// result flags and valid in the other.
interface cla_adder_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;
  logic             p_out;
  logic             g_out;
  logic             out_valid;

  modport master (
    output a, b, c_in, in_valid,
    input  sum, c_out, overflow, p_out, g_out, out_valid
  );

  modport slave (
    input  a, b, c_in, in_valid,
    output sum, c_out, overflow, p_out, g_out, out_valid
  );
endinterface

// File: rtl/cla_adder.sv
// Two-level carry-lookahead adder: 4-bit lookahead blocks joined by a block-level
// lookahead, with all results registered one cycle after an accepted sample.
module cla_adder #(
  parameter int unsigned WIDTH = 4
) (
  input logic        clk,
  input logic        rst_n,
  cla_adder_if.slave bus
);

  localparam int NumBlk = int'(WIDTH / 4);

  if (WIDTH == 0 || (WIDTH % 4) != 0) begin : gen_bad_width
    $error("cla_adder: WIDTH must be a positive multiple of 4");
  end

  logic [WIDTH-1:0]  g, p, c;
  logic [NumBlk-1:0] blk_p, blk_g;
  logic [NumBlk:0]   blk_c;
  logic [NumBlk:0]   gen_cin, gen_zero;
  logic              grp_g;

  assign g = bus.a & bus.b;
  assign p = bus.a ^ bus.b;

  for (genvar k = 0; k < NumBlk; k++) begin : gen_blk
    logic [3:0] gb, pb;
    logic       ci;
    assign gb = g[4*k +: 4];
    assign pb = p[4*k +: 4];
    assign ci = blk_c[k];

    assign blk_p[k] = &pb;
    assign blk_g[k] = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
                    | (pb[3] & pb[2] & pb[1] & gb[0]);

    assign c[4*k]   = ci;
    assign c[4*k+1] = gb[0] | (pb[0] & ci);
    assign c[4*k+2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & ci);
    assign c[4*k+3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
                    | (pb[2] & pb[1] & pb[0] & ci);
  end

  // Slot 0 is the carry source below block 0; slot j+1 is block j's generate.
  assign gen_cin  = {blk_g, bus.c_in};
  assign gen_zero = {blk_g, 1'b0};

  // Block carries as a flat sum-of-products over block P/G, no ripple between blocks.
  always_comb begin
    logic term;
    term  = 1'b0;
    blk_c = '0;
    grp_g = 1'b0;
    for (int k = 0; k <= NumBlk; k++) begin
      for (int j = 0; j <= k; j++) begin
        term = gen_cin[j];
        for (int m = j; m < k; m++) term = term & blk_p[m];
        blk_c[k] = blk_c[k] | term;
      end
    end
    for (int j = 0; j <= NumBlk; j++) begin
      term = gen_zero[j];
      for (int m = j; m < NumBlk; m++) term = term & blk_p[m];
      grp_g = grp_g | term;
    end
  end

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             c_out_q, overflow_q, p_out_q, g_out_q, out_valid_q;

  assign sum_d = p ^ c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      overflow_q  <= 1'b0;
      p_out_q     <= 1'b0;
      g_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        sum_q      <= sum_d;
        c_out_q    <= blk_c[NumBlk];
        overflow_q <= c[WIDTH-1] ^ blk_c[NumBlk];
        p_out_q    <= &blk_p;
        g_out_q    <= grp_g;
      end
    end
  end

  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.p_out     = p_out_q;
  assign bus.g_out     = g_out_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_cla_adder.sv
// Bench for cla_adder at WIDTH 4 (table + exhaustive) and WIDTH 16 (random), with
// hand-written hold and reset sequences.
module tb_cla_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cla_adder_if #(.WIDTH(4))  bus4 ();
  cla_adder_if #(.WIDTH(16)) bus16 ();

  cla_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
  cla_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  // Packed result: {out_valid, g_out, p_out, overflow, c_out, sum zero-extended to 16}
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [3:0] sum;
    logic       co;
    logic       ov;
    logic       p;
    logic       g;
  } vec_t;

  function automatic logic [20:0] model(int w, logic [15:0] a, logic [15:0] b, logic c);
    longint unsigned mask, half, full;
    longint          sa, sb, sres;
    logic            co, ov, pp, gg;
    logic [15:0]     s;
    mask = (64'd1 << w) - 64'd1;
    half = 64'd1 << (w - 1);
    full = 64'(a) + 64'(b) + 64'(c);
    s    = 16'(full & mask);
    co   = (full >> w) != 0;
    sa   = (64'(a) >= half) ? longint'(a) - longint'(mask + 1) : longint'(a);
    sb   = (64'(b) >= half) ? longint'(b) - longint'(mask + 1) : longint'(b);
    sres = sa + sb + longint'(c);
    ov   = (sres > longint'(half) - 1) || (sres < -longint'(half));
    pp   = ((64'(a) ^ 64'(b)) & mask) == mask;
    gg   = ((64'(a) + 64'(b)) >> w) != 0;
    return {1'b1, gg, pp, ov, co, s};
  endfunction

  function automatic logic [20:0] got(int w);
    if (w == 4)
      return {bus4.out_valid, bus4.g_out, bus4.p_out, bus4.overflow, bus4.c_out, 12'd0, bus4.sum};
    return {bus16.out_valid, bus16.g_out, bus16.p_out, bus16.overflow, bus16.c_out, bus16.sum};
  endfunction

  task automatic check(string name, logic [20:0] act, logic [20:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {vld,g,p,ovf,co,sum}=%h want %h", name, act, exp);
    end
  endtask

  task automatic apply(int w, logic [15:0] a, logic [15:0] b, logic c, logic v);
    bus4.in_valid  = 1'b0;
    bus16.in_valid = 1'b0;
    if (w == 4) begin
      bus4.a = a[3:0]; bus4.b = b[3:0]; bus4.c_in = c; bus4.in_valid = v;
    end else begin
      bus16.a = a; bus16.b = b; bus16.c_in = c; bus16.in_valid = v;
    end
  endtask

  // One sample per cycle; the result of each is checked on the following negedge.
  logic        pend = 1'b0;
  int          pend_w;
  logic [20:0] pend_exp;
  string       pend_name;

  task automatic drive(int w, string name, logic [15:0] a, logic [15:0] b, logic c,
                       logic [20:0] exp);
    @(negedge clk);
    if (pend) check(pend_name, got(pend_w), pend_exp);
    apply(w, a, b, c, 1'b1);
    pend = 1'b1; pend_w = w; pend_exp = exp; pend_name = name;
  endtask

  task automatic flush();
    @(negedge clk);
    if (pend) check(pend_name, got(pend_w), pend_exp);
    apply(4, 16'd0, 16'd0, 1'b0, 1'b0);
    pend = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    logic [15:0] ra, rb;
    logic        rc;

    vecs[0] = '{4'd4,  4'd5,  1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{4'd4,  4'd3,  1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0}; // a^b = 4'b0111
    vecs[2] = '{4'd15, 4'd0,  1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{4'd15, 4'd15, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{4'd0,  4'd0,  1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{4'd7,  4'd1,  1'b0, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{4'd8,  4'd8,  1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{4'd10, 4'd5,  1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{4'd10, 4'd5,  1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0};

    apply(4, 16'd0, 16'd0, 1'b0, 1'b0);
    #1;
    check("reset4", got(4), 21'd0);
    check("reset16", got(16), 21'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      drive(4, $sformatf("table%0d", i), {12'd0, vecs[i].a}, {12'd0, vecs[i].b}, vecs[i].c,
            {1'b1, vecs[i].g, vecs[i].p, vecs[i].ov, vecs[i].co, 12'd0, vecs[i].sum});
    drive(16, "chain16", 16'hAAAA, 16'h5555, 1'b1, {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000});
    flush();

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          drive(4, "exh4", 16'(a), 16'(b), 1'(c), model(4, 16'(a), 16'(b), 1'(c)));
    flush();

    for (int i = 0; i < 1500; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      drive(16, "rand16", ra, rb, rc, model(16, ra, rb, rc));
    end
    flush();

    // Single valid sample, then three idle cycles with garbage operands.
    @(negedge clk);
    apply(4, 16'd4, 16'd5, 1'b1, 1'b1);
    @(negedge clk);
    check("hold_load", got(4), {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 4'hA});
    bus4.in_valid = 1'b0;
    bus4.a = 'x; bus4.b = 'x; bus4.c_in = 'x;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d", i), got(4), {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 4'hA});
    end

    // Asynchronous reset mid-hold, with a valid sample presented during reset.
    #2;
    rst_n = 1'b0;
    apply(4, 16'd15, 16'd15, 1'b1, 1'b1);
    #1;
    check("reset_async", got(4), 21'd0);
    @(negedge clk);
    check("reset_ignore", got(4), 21'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_accept", got(4), {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'd0, 4'hF});

    // A sample loaded just before reset assertion is discarded.
    apply(4, 16'd4, 16'd3, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("discard_on_reset", got(4), 21'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(4, 16'd0, 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("after_discard", got(4), 21'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
